// File: rtl/nibbler_fetch_seq_pkg.sv
// Shared types and constants for the Nibbler fetch sequencer: FSM state
// encoding, jump opcodes, flag bit positions and jump-resolution helpers.
package nibbler_pkg;

  typedef enum logic [2:0] {
    S_ADDR  = 3'd0,
    S_LOAD  = 3'd1,
    S_EXEC  = 3'd2,
    S_ADDR2 = 3'd3,
    S_LOAD2 = 3'd4
  } state_t;

  localparam logic [3:0] OP_JC  = 4'h8;
  localparam logic [3:0] OP_JNC = 4'h9;
  localparam logic [3:0] OP_JMP = 4'hA;
  localparam logic [3:0] OP_JZ  = 4'hB;

  localparam int FLAG_C = 1;
  localparam int FLAG_Z = 0;

  // Two-byte instructions: the second byte is the low half of the target.
  function automatic logic is_jump(input logic [3:0] op);
    return (op == OP_JC) || (op == OP_JNC) || (op == OP_JMP) || (op == OP_JZ);
  endfunction

  function automatic logic jump_taken(input logic [3:0] op, input logic [1:0] flags);
    logic taken;
    taken = 1'b0;
    case (op)
      OP_JMP:  taken = 1'b1;
      OP_JC:   taken = flags[FLAG_C];
      OP_JNC:  taken = ~flags[FLAG_C];
      OP_JZ:   taken = flags[FLAG_Z];
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/nibbler_fetch_seq_if.sv
// ROM, flag and decoder-side signals of the Nibbler fetch sequencer.
// Optional halt/halted pair exists only when NIBBLER_FETCH_HALT_EN is defined.
interface nibbler_fetch_seq_if #(
  parameter int ADDR_W = 12
);

  // Handshakes: rom_rd=1 in a cycle means rom_data carries mem[rom_addr] in the
  // following cycle (no stall, no ready); instr_valid is a one-cycle execute
  // strobe with no backpressure, opcode/operand/pc are stable while it is high.
  logic [ADDR_W-1:0] rom_addr;
  logic              rom_rd;
  logic [7:0]        rom_data;
  logic [1:0]        flags;
  logic [3:0]        opcode;
  logic [3:0]        operand;
  logic              instr_valid;
  logic [ADDR_W-1:0] pc;
`ifdef NIBBLER_FETCH_HALT_EN
  logic              halt;
  logic              halted;

  modport master (
    output rom_addr, rom_rd, opcode, operand, instr_valid, pc, halted,
    input  rom_data, flags, halt
  );

  modport slave (
    input  rom_addr, rom_rd, opcode, operand, instr_valid, pc, halted,
    output rom_data, flags, halt
  );
`else
  modport master (
    output rom_addr, rom_rd, opcode, operand, instr_valid, pc,
    input  rom_data, flags
  );

  modport slave (
    input  rom_addr, rom_rd, opcode, operand, instr_valid, pc,
    output rom_data, flags
  );
`endif

endinterface

// File: rtl/nibbler_fetch_seq_pc_reg.sv
// Program counter register: parallel load or increment, modulo 2^ADDR_W.
module nibbler_pc_reg #(
  parameter int                ADDR_W       = 12,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic              inc,
  input  logic [ADDR_W-1:0] load_val,
  output logic [ADDR_W-1:0] pc
);

  // Natural overflow of the ADDR_W-bit add gives the FFF -> 000 wrap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc <= RESET_VECTOR;
    end else if (load) begin
      pc <= load_val;
    end else if (inc) begin
      pc <= pc + 1'b1;
    end
  end

endmodule

// File: rtl/nibbler_fetch_seq.sv
// Nibbler 4-bit CPU instruction fetch sequencer: PC, ROM fetch, IR latch and
// two-byte jump resolution. Define NIBBLER_FETCH_HALT_EN to add halt/halted.
module nibbler_fetch_seq
  import nibbler_pkg::*;
#(
  parameter int                ADDR_W       = 12,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
  input  logic                clk,
  input  logic                reset_n,
  nibbler_fetch_seq_if.master bus,
  output state_t              state_dbg
);

  state_t            state_q;
  state_t            state_d;
  logic [7:0]        ir_q;
  logic              ir_load;
  logic              pc_inc;
  logic              pc_load;
  logic [ADDR_W-1:0] pc_load_val;
  logic [ADDR_W-1:0] pc_q;
  logic              rom_rd;
  logic              instr_valid;
  logic              halt_req;

`ifdef NIBBLER_FETCH_HALT_EN
  assign halt_req = bus.halt;
`else
  assign halt_req = 1'b0;
`endif

  nibbler_pc_reg #(
    .ADDR_W      (ADDR_W),
    .RESET_VECTOR(RESET_VECTOR)
  ) u_pc_reg (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (pc_load),
    .inc     (pc_inc),
    .load_val(pc_load_val),
    .pc      (pc_q)
  );

  // The high target nibble was latched with the opcode; the low byte arrives now.
  assign pc_load_val = ADDR_W'({ir_q[3:0], bus.rom_data});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_ADDR;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ir_q <= 8'h00;
    end else if (ir_load) begin
      ir_q <= bus.rom_data;
    end
  end

  always_comb begin
    state_d     = state_q;
    ir_load     = 1'b0;
    pc_inc      = 1'b0;
    pc_load     = 1'b0;
    rom_rd      = 1'b0;
    instr_valid = 1'b0;
    case (state_q)
      S_ADDR: begin
        // Halt is only honoured here, so it always lands on an instruction boundary.
        if (!halt_req) begin
          rom_rd  = 1'b1;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        ir_load = 1'b1;
        pc_inc  = 1'b1;
        state_d = is_jump(bus.rom_data[7:4]) ? S_ADDR2 : S_EXEC;
      end
      S_EXEC: begin
        instr_valid = 1'b1;
        state_d     = S_ADDR;
      end
      S_ADDR2: begin
        rom_rd  = 1'b1;
        state_d = S_LOAD2;
      end
      S_LOAD2: begin
        if (jump_taken(ir_q[7:4], bus.flags)) begin
          pc_load = 1'b1;
        end else begin
          pc_inc = 1'b1;
        end
        state_d = S_ADDR;
      end
      default: begin
        state_d = S_ADDR;
      end
    endcase
  end

  assign bus.rom_addr    = pc_q;
  assign bus.rom_rd      = rom_rd;
  assign bus.pc          = pc_q;
  assign bus.opcode      = ir_q[7:4];
  assign bus.operand     = ir_q[3:0];
  assign bus.instr_valid = instr_valid;
  assign state_dbg       = state_q;

`ifdef NIBBLER_FETCH_HALT_EN
  assign bus.halted = (state_q == S_ADDR) && bus.halt;
`endif

endmodule

// File: tb/tb_nibbler_fetch_seq.sv
// Bench for nibbler_fetch_seq: instruction-level reference model predicts the
// execute strobes and the per-cycle pc/ROM request sequence of each run.
module tb_nibbler_fetch_seq;
  import nibbler_pkg::*;

  localparam int          ADDR_W = 12;
  localparam logic [11:0] RV     = 12'h000;
  localparam int          MAXC   = 1024;
  localparam int          W      = 36;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  nibbler_fetch_seq_if #(.ADDR_W(ADDR_W)) bus();
  state_t state_dbg;

  nibbler_fetch_seq #(
    .ADDR_W      (ADDR_W),
    .RESET_VECTOR(RV)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus),
    .state_dbg(state_dbg)
  );

  logic [7:0]  rom [4096];
  logic [1:0]  flags_seq [MAXC];
  logic [11:0] exp_pc [MAXC];
  logic        exp_rd [MAXC];
  logic [W-1:0] exp_q[$];  // {exec cycle[35:20], pc during exec[19:8], instruction byte[7:0]}

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int first_tj = -1;
  bit mon_en = 1'b0;

  // Synchronous ROM: data for the address requested this cycle appears next cycle.
  always @(posedge clk) begin
    if (bus.rom_rd) bus.rom_data <= rom[bus.rom_addr];
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Architectural model: walk the program instruction by instruction, advancing
  // time by 3 cycles per plain instruction and 4 per jump.
  task automatic build_model(input int abort);
    logic [11:0] p, p1;
    logic [7:0]  b, low;
    logic [3:0]  op;
    logic [1:0]  fl;
    logic        taken;
    int          t;
    p = RV;
    t = 0;
    first_tj = -1;
    exp_q.delete();
    while (t < abort) begin
      b  = rom[p];
      op = b[7:4];
      p1 = p + 12'd1;
      exp_pc[t] = p;  exp_pc[t+1] = p;  exp_rd[t] = 1'b1;  exp_rd[t+1] = 1'b0;
      if (op == 4'h8 || op == 4'h9 || op == 4'hA || op == 4'hB) begin
        low = rom[p1];
        fl = flags_seq[t+3];
        taken = (op == 4'hA) || (op == 4'h8 && fl[1]) || (op == 4'h9 && !fl[1]) ||
                (op == 4'hB && fl[0]);
        exp_pc[t+2] = p1;  exp_pc[t+3] = p1;  exp_rd[t+2] = 1'b1;  exp_rd[t+3] = 1'b0;
        if (taken && first_tj < 0) first_tj = t + 3;
        p = taken ? {b[3:0], low} : p1 + 12'd1;
        t += 4;
      end else begin
        exp_pc[t+2] = p1;  exp_rd[t+2] = 1'b0;
        if (t + 2 < abort) exp_q.push_back({16'(t + 2), p1, b});
        p = p1;
        t += 3;
      end
    end
  endtask

  always @(negedge clk) begin
    logic [W-1:0] e;
    if (mon_en && reset_n) begin
      if (cyc < MAXC) begin
        chk("pc", W'(bus.pc), W'(exp_pc[cyc]));
        chk("rom_addr", W'(bus.rom_addr), W'(exp_pc[cyc]));
        chk("rom_rd", W'(bus.rom_rd), W'(exp_rd[cyc]));
      end
      if (bus.instr_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_exec", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("exec_cycle", W'(cyc), W'(e[35:20]));
          chk("opcode", W'(bus.opcode), W'(e[7:4]));
          chk("operand", W'(bus.operand), W'(e[3:0]));
        end
      end
    end
  end

  task automatic check_reset_state(input string tag);
    chk({tag, "_pc"}, W'(bus.pc), W'(RV));
    chk({tag, "_rom_addr"}, W'(bus.rom_addr), W'(RV));
    chk({tag, "_rom_rd"}, W'(bus.rom_rd), 1);
    chk({tag, "_ir"}, W'({bus.opcode, bus.operand}), 0);
    chk({tag, "_instr_valid"}, W'(bus.instr_valid), 0);
    chk({tag, "_state"}, W'(state_dbg), W'(S_ADDR));
  endtask

  // Release reset, run until cycle 'abort', then assert reset mid-cycle.
  task automatic run_phase(input int abort);
    @(negedge clk);
    #1;
    cyc = 0;
    bus.flags = flags_seq[0];
    reset_n = 1'b1;
    mon_en = 1'b1;
    while (1) begin
      @(posedge clk);
      cyc++;
      if (cyc == abort) begin
        #2;
        reset_n = 1'b0;
        break;
      end
      #1;
      bus.flags = flags_seq[cyc];
    end
    mon_en = 1'b0;
    #1;
    check_reset_state("abort");
    chk("missing_exec", W'(exp_q.size()), 0);
  endtask

  task automatic load_directed();
    for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
    rom[12'h000] = 8'h35;
    rom[12'h001] = 8'hA4;  rom[12'h002] = 8'h20;  // JMP 420
    rom[12'h420] = 8'hA0;  rom[12'h421] = 8'h10;  // JMP 010
    rom[12'h010] = 8'h84;  rom[12'h011] = 8'h40;  // JC 440
    rom[12'h012] = 8'hAF;  rom[12'h013] = 8'hFD;  // JMP FFD
    rom[12'hFFD] = 8'h77;
    rom[12'hFFE] = 8'hB3;  rom[12'hFFF] = 8'h00;  // JZ 300, low byte at FFF
    rom[12'h440] = 8'h9F;  rom[12'h441] = 8'hFF;  // JNC FFF
    rom[12'h442] = 8'hAF;  rom[12'h443] = 8'hFF;  // JMP FFF
  endtask

  task automatic fill_flags(input logic [1:0] f, input bit rnd);
    for (int i = 0; i < MAXC; i++) flags_seq[i] = rnd ? 2'($urandom_range(0, 3)) : f;
  endtask

  initial begin
    int abort;
    logic [3:0] op;
    bus.flags = 2'b00;
`ifdef NIBBLER_FETCH_HALT_EN
    bus.halt = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset");

    // C=0,Z=0: JC falls through, JZ at FFE wraps to 000.
    load_directed();
    fill_flags(2'b00, 1'b0);
    build_model(120);
    run_phase(120);

    // C=1: JC taken to 440, JNC falls through, plain instruction at FFF wraps.
    fill_flags(2'b10, 1'b0);
    build_model(120);
    run_phase(120);

    // Reset during S_LOAD2 of the first taken jump (JMP 420).
    fill_flags(2'b00, 1'b0);
    build_model(120);
    abort = (first_tj > 0) ? first_tj : 50;
    build_model(abort);
    run_phase(abort);

    for (int ph = 0; ph < 6; ph++) begin
      for (int i = 0; i < 4096; i++) begin
        op = ($urandom_range(0, 99) < 35) ? 4'(8 + $urandom_range(0, 3)) : 4'($urandom_range(0, 15));
        rom[i] = {op, 4'($urandom_range(0, 15))};
      end
      fill_flags(2'b00, 1'b1);
      abort = $urandom_range(150, 400);
      build_model(abort);
      run_phase(abort);
    end

`ifdef NIBBLER_FETCH_HALT_EN
    begin
      int n;
      load_directed();
      bus.flags = 2'b00;
      @(negedge clk);
      #1;
      reset_n = 1'b1;
      n = 0;
      while (!bus.instr_valid && n < 10) begin
        @(negedge clk);
        n++;
      end
      chk("halt_reach_exec", W'(bus.instr_valid), 1);
      #1;
      bus.halt = 1'b1;
      @(negedge clk);
      chk("halted", W'(bus.halted), 1);
      chk("halt_rom_rd", W'(bus.rom_rd), 0);
      chk("halt_pc", W'(bus.pc), 12'h001);
      repeat (3) @(negedge clk);
      chk("halt_hold_pc", W'(bus.pc), 12'h001);
      chk("halt_hold_state", W'(state_dbg), W'(S_ADDR));
      #1;
      bus.halt = 1'b0;
      #1;
      chk("resume_rom_rd", W'(bus.rom_rd), 1);
      chk("resume_rom_addr", W'(bus.rom_addr), 12'h001);
      chk("resume_halted", W'(bus.halted), 0);
      @(negedge clk);
      chk("resume_state", W'(state_dbg), W'(S_LOAD));
      reset_n = 1'b0;
      #1;
      check_reset_state("halt_reset");
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
